// File: rtl/tft_call_seq.sv
// tft_call_seq: steps through a latched program of one-hot calls to a base module,
// with per-call timeout, optional looping, abort and a sticky error flag.
module tft_call_seq #(
  parameter int N_CALL  = 3,
  parameter int SEQ_LEN = 4,
  parameter int ID_W    = 2,
  parameter int TMO     = 1000000,
  localparam int SW     = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1,
  localparam int CW     = $clog2(TMO) + 1
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    iStart,
  input  logic [SEQ_LEN*ID_W-1:0] iSeq,
  input  logic                    iLoop,
  input  logic                    iAbort,
  input  logic                    iDone,
  output logic [N_CALL-1:0]       oCall,
  output logic                    oBusy,
  output logic                    oDone,
  output logic                    oErr,
  output logic [SW-1:0]           oStep
);
  typedef enum logic [2:0] {IDLE, FETCH, CALL, GAP, FIN, ERR} state_t;
  state_t                  state_q, state_d;
  logic [SEQ_LEN*ID_W-1:0] prog_q, prog_d;
  logic [SW-1:0]           step_q, step_d;
  logic [N_CALL-1:0]       call_q, call_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [ID_W-1:0]         entry;
  assign entry = prog_q[step_q*ID_W +: ID_W];
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      prog_q  <= '0;
      step_q  <= '0;
      call_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      step_q  <= step_d;
      call_q  <= call_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // Abort outranks every in-state decision, including iDone and timeout.
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    step_d  = step_q;
    call_d  = call_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (iAbort && state_q != IDLE) begin
      state_d = IDLE;
      call_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (iStart) begin
          prog_d  = iSeq;
          step_d  = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
        FETCH: if (entry == '0) state_d = FIN;
        else if (entry > ID_W'(N_CALL)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          call_d  = N_CALL'(1) << (entry - ID_W'(1));
          cnt_d   = '0;
          state_d = CALL;
        end
        CALL: if (iDone) begin
          call_d  = '0;
          state_d = GAP;
        end else if (cnt_q == CW'(TMO - 1)) begin
          call_d  = '0;
          err_d   = 1'b1;
          state_d = ERR;
        end else cnt_d = cnt_q + CW'(1);
        GAP: if (step_q == SW'(SEQ_LEN - 1)) state_d = FIN;
        else begin
          step_d  = step_q + SW'(1);
          state_d = FETCH;
        end
        FIN: if (iLoop) begin
          step_d  = '0;
          state_d = FETCH;
        end else state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    oCall = call_q;
    oBusy = state_q != IDLE;
    oDone = state_q == FIN && !iAbort;
    oErr  = err_q;
    oStep = step_q;
  end
endmodule

// File: tb/tb_tft_call_seq.sv
// tb_tft_call_seq: directed scenarios for the call sequencer; a negedge monitor logs
// the call pattern, zero gaps and oDone pulses, a responder answers each call after 5 cycles.
module tb_tft_call_seq;
  logic clk = 0, rst = 0, start = 0, loop = 0, abort = 0, man_done = 0, auto_idone = 0, auto_done = 0;
  logic done;
  logic [5:0] seq = '0;
  logic [2:0] call;
  logic [1:0] call2, step, step2;
  logic busy, dn, err, busy2, dn2, err2;
  int errors = 0, checks = 0, done_cnt = 0, bad = 0, zrun = 0, hc = 0;
  bit had = 0;
  logic [2:0] prev = '0;
  logic [2:0] calls[$];
  int gaps[$];
  logic [2:0] ex[3] = '{3'b001, 3'b010, 3'b100};
  assign done = man_done | auto_idone;
  always #5 clk = ~clk;
  tft_call_seq #(.N_CALL(3), .SEQ_LEN(3), .ID_W(2), .TMO(16)) u (
    .CLOCK(clk), .RESET(rst), .iStart(start), .iSeq(seq), .iLoop(loop), .iAbort(abort),
    .iDone(done), .oCall(call), .oBusy(busy), .oDone(dn), .oErr(err), .oStep(step));
  tft_call_seq #(.N_CALL(2), .SEQ_LEN(3), .ID_W(2), .TMO(16)) u2 (
    .CLOCK(clk), .RESET(rst), .iStart(start), .iSeq(seq), .iLoop(loop), .iAbort(abort),
    .iDone(done), .oCall(call2), .oBusy(busy2), .oDone(dn2), .oErr(err2), .oStep(step2));
  always @(negedge clk) begin
    if ($countones(call) > 1) bad++;
    if (dn === 1'b1) done_cnt++;
    if (call != 0 && prev == 0) begin
      if (had) gaps.push_back(zrun);
      calls.push_back(call);
      had = 1;
      zrun = 0;
    end else if (call == 0 && had) zrun++;
    prev = call;
  end
  always @(negedge clk) begin
    if (!auto_done || call == 0) begin
      hc = 0;
      auto_idone = 0;
    end else begin
      hc++;
      auto_idone = (hc == 5);
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic clr;
    calls.delete(); gaps.delete();
    done_cnt = 0; bad = 0; zrun = 0; had = 0; prev = '0;
  endtask
  task automatic do_reset;
    rst = 1; cyc(2); rst = 0; clr();
  endtask
  task automatic go(input logic [5:0] s);
    seq = s; start = 1; cyc(1); start = 0;
  endtask
  task automatic test_reset;
    start = 1; seq = 6'b111001; abort = 0; rst = 1;
    cyc(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (call !== 3'b000) begin errors++; $display("FAIL reset_call: got %0b expected 000", call); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", dn); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
    start = 0; rst = 0; cyc(1);
  endtask
  task automatic test_sequence;
    int n = 0;
    do_reset(); auto_done = 1;
    go(6'b111001);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy_fetch: got %0b expected 1", busy); end
    checks++; if (call !== 3'b000) begin errors++; $display("FAIL seq_call_fetch: got %0b expected 000", call); end
    cyc(1);
    checks++; if (call !== 3'b001) begin errors++; $display("FAIL seq_latency: got %0b expected 001", call); end
    while (busy && n < 200) begin cyc(1); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_idle: got %0b expected 0", busy); end
    checks++; if (calls.size() != 3) begin errors++; $display("FAIL seq_ncalls: got %0d expected 3", calls.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (calls[i] !== ex[i]) begin errors++; $display("FAIL seq_call%0d: got %0b expected %0b", i, calls[i], ex[i]); end
    end
    checks++; if (gaps.size() != 2 || gaps[0] != 2 || gaps[1] != 2) begin errors++; $display("FAIL seq_gaps: got %0d gaps first %0d expected 2 gaps of 2", gaps.size(), gaps.size() > 0 ? gaps[0] : -1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL seq_done: got %0d expected 1", done_cnt); end
    checks++; if (bad != 0) begin errors++; $display("FAIL seq_onehot: got %0d expected 0", bad); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL seq_err: got %0b expected 0", err); end
  endtask
  task automatic test_early_end;
    int n = 0;
    do_reset(); auto_done = 1;
    go(6'b001001);
    while (busy && n < 200) begin cyc(1); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_idle: got %0b expected 0", busy); end
    checks++; if (calls.size() != 2) begin errors++; $display("FAIL early_ncalls: got %0d expected 2", calls.size()); end
    else begin
      checks++; if (calls[0] !== 3'b001 || calls[1] !== 3'b010) begin errors++; $display("FAIL early_calls: got %0b,%0b expected 001,010", calls[0], calls[1]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL early_done: got %0d expected 1", done_cnt); end
  endtask
  task automatic test_timeout;
    int n = 0;
    do_reset(); auto_done = 0;
    go(6'b000001); cyc(1);
    while (call != 0 && n < 40) begin n++; cyc(1); end
    checks++; if (n != 16) begin errors++; $display("FAIL tmo_cycles: got %0d expected 16", n); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0b expected 1", err); end
    cyc(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got %0b expected 0", busy); end
    cyc(3);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %0b expected 1", err); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL tmo_nodone: got %0d expected 0", done_cnt); end
    go(6'b000000);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %0b expected 0", err); end
    n = 0;
    while (busy && n < 20) begin cyc(1); n++; end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL tmo_empty_done: got %0d expected 1", done_cnt); end
  endtask
  task automatic test_invalid;
    int n = 0;
    bit seen = 0;
    do_reset(); auto_done = 1;
    go(6'b000011);
    seen |= dn2;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL inv_busy: got %0b expected 1", busy2); end
    cyc(1); seen |= dn2;
    checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL inv_err: got %0b expected 1", err2); end
    checks++; if (call2 !== 2'b00) begin errors++; $display("FAIL inv_call: got %0b expected 00", call2); end
    cyc(1); seen |= dn2;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL inv_idle: got %0b expected 0", busy2); end
    cyc(2); seen |= dn2;
    checks++; if (err2 !== 1'b1 || call2 !== 2'b00) begin errors++; $display("FAIL inv_hold: got err=%0b call=%0b expected err=1 call=00", err2, call2); end
    checks++; if (seen) begin errors++; $display("FAIL inv_nodone: got 1 expected 0"); end
    while (busy && n < 200) begin cyc(1); n++; end
  endtask
  task automatic test_loop;
    int n = 0;
    do_reset(); auto_done = 1; loop = 1;
    go(6'b111001); seq = 6'b000000;
    while (done_cnt < 2 && n < 300) begin cyc(1); n++; end
    loop = 0; n = 0;
    while (busy && n < 300) begin cyc(1); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_idle: got %0b expected 0", busy); end
    checks++; if (done_cnt != 3) begin errors++; $display("FAIL loop_done: got %0d expected 3", done_cnt); end
    checks++; if (calls.size() != 9) begin errors++; $display("FAIL loop_ncalls: got %0d expected 9", calls.size()); end
    else for (int i = 0; i < 9; i++) begin
      checks++; if (calls[i] !== ex[i%3]) begin errors++; $display("FAIL loop_call%0d: got %0b expected %0b", i, calls[i], ex[i%3]); end
    end
    checks++; if (gaps.size() != 8) begin errors++; $display("FAIL loop_ngaps: got %0d expected 8", gaps.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (gaps[i] != (i % 3 == 2 ? 3 : 2)) begin errors++; $display("FAIL loop_gap%0d: got %0d expected %0d", i, gaps[i], i % 3 == 2 ? 3 : 2); end
    end
  endtask
  task automatic test_abort(input bit use_rst);
    int n = 0;
    do_reset(); auto_done = 1;
    go(6'b111001);
    while (call !== 3'b010 && n < 100) begin cyc(1); n++; end
    checks++; if (call !== 3'b010) begin errors++; $display("FAIL ab%0d_second_call: got %0b expected 010", use_rst, call); end
    auto_done = 0; cyc(2);
    if (use_rst) rst = 1; else abort = 1;
    man_done = 1; cyc(1);
    rst = 0; abort = 0; man_done = 0;
    checks++; if (call !== 3'b000) begin errors++; $display("FAIL ab%0d_call_drop: got %0b expected 000", use_rst, call); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab%0d_idle: got %0b expected 0", use_rst, busy); end
    cyc(10);
    checks++; if (calls.size() != 2) begin errors++; $display("FAIL ab%0d_no_resume: got %0d calls expected 2", use_rst, calls.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL ab%0d_nodone: got %0d expected 0", use_rst, done_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ab%0d_err: got %0b expected 0", use_rst, err); end
    if (use_rst) begin
      checks++; if (step !== 2'd0) begin errors++; $display("FAIL ab1_step: got %0d expected 0", step); end
    end
  endtask
  initial begin
    test_reset();
    test_sequence();
    test_early_end();
    test_timeout();
    test_invalid();
    test_loop();
    test_abort(0);
    test_abort(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
